adc_spi_capture: RTL

Parametrised multi-channel serial ADC capture engine: generates chip-select and serial clock for NUM_CH simultaneously-sampling ADCs sharing one cs_n/sclk. It deserialises one DATA_W-bit word per channel per conversion and presents all channels as one packed AXI-Stream-style word with framing (tlast) for the downstream trigger/FFT path. It supersedes the fixed two-channel, 10-bit capture with configurable width, channel count, clock division, triggered or continuous mode, output sign format, and overrun detection.

---
 rtl/adc_spi_capture.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/adc_spi_capture.sv
// Multi-channel serial ADC capture: drives a shared cs_n/sclk and deserialises one word per lane.
// Each conversion is presented as one packed stream word with overrun detection and frame framing.
module adc_spi_capture #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned DATA_W     = 10,
  parameter int unsigned LEAD_BITS  = 4,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned GAP_CYC    = 4,
  parameter int unsigned FRAME_LEN  = 256,
  parameter int unsigned SIGNED_OUT = 0
) (
  input  logic                     clk,
  input  logic                     reset_b,
  input  logic                     en,
  input  logic                     cont,
  input  logic                     start,
  input  logic                     ovr_clr,
  input  logic [NUM_CH-1:0]        sdi,
  output logic                     cs_n,
  output logic                     sclk,
  output logic                     busy,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [NUM_CH*DATA_W-1:0] m_tdata,
  output logic                     m_tlast,
  output logic                     overrun
);

  localparam int unsigned NBits  = LEAD_BITS + DATA_W;
  localparam int unsigned DivMax = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int unsigned DivW   = $clog2(DivMax + 1);
  localparam int unsigned BitW   = $clog2(NBits + 1);
  localparam int unsigned CntW   = $clog2(FRAME_LEN);
  localparam int unsigned WordW  = NUM_CH * DATA_W;

  typedef enum logic [1:0] {StIdle, StSetup, StShift, StGap} state_e;

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic              cs_n_q, cs_n_d;
  logic              sclk_q, sclk_d;
  logic [WordW-1:0]  sh_q, sh_d;
  logic [WordW-1:0]  tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d;
  logic              ovr_q, ovr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WordW-1:0]  word_fmt;
  logic              sample;
  logic              load;
  logic              hs;
  logic              div_last;
  logic              gap_last;

  assign div_last = (div_q == DivW'(CLK_DIV - 1));
  assign gap_last = (div_q == DivW'(GAP_CYC - 1));

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    sample  = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en && (cont || start)) begin
          state_d = StSetup;
          cs_n_d  = 1'b0;
          div_d   = '0;
        end
      end
      StSetup: begin
        if (div_last) begin
          state_d = StShift;
          sclk_d  = 1'b1;
          div_d   = '0;
          bit_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StShift: begin
        if (!div_last) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          if (sclk_q) begin
            // Falling sclk edge: ADC data has been stable for a full high phase.
            sclk_d = 1'b0;
            sample = 1'b1;
          end else if (bit_q == BitW'(NBits - 1)) begin
            cs_n_d  = 1'b1;
            load    = 1'b1;
            state_d = StGap;
          end else begin
            sclk_d = 1'b1;
            bit_d  = bit_q + 1'b1;
          end
        end
      end
      StGap: begin
        if (!gap_last) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          if (en && cont) begin
            state_d = StSetup;
            cs_n_d  = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Lead bits are shifted through too; after NBits samples only the last DATA_W remain.
  always_comb begin
    sh_d = sh_q;
    if (sample) begin
      for (int c = 0; c < NUM_CH; c++) begin
        sh_d[c*DATA_W +: DATA_W] = {sh_q[c*DATA_W +: DATA_W-1], sdi[c]};
      end
    end
  end

  always_comb begin
    word_fmt = sh_q;
    if (SIGNED_OUT != 0) begin
      for (int c = 0; c < NUM_CH; c++) begin
        word_fmt[c*DATA_W + DATA_W - 1] = ~sh_q[c*DATA_W + DATA_W - 1];
      end
    end
  end

  assign hs = tvalid_q && m_tready;

  always_comb begin
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    ovr_d    = ovr_q;
    cnt_d    = cnt_q;
    if (load) begin
      tvalid_d = 1'b1;
      tdata_d  = word_fmt;
    end else if (hs) begin
      tvalid_d = 1'b0;
    end
    // Setting beats a simultaneous clear so no overwrite is ever lost.
    if (load && tvalid_q && !m_tready) begin
      ovr_d = 1'b1;
    end else if (ovr_clr) begin
      ovr_d = 1'b0;
    end
    if (hs) begin
      cnt_d = (cnt_q == CntW'(FRAME_LEN - 1)) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q  <= StIdle;
      div_q    <= '0;
      bit_q    <= '0;
      cs_n_q   <= 1'b1;
      sclk_q   <= 1'b0;
      sh_q     <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      ovr_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      cs_n_q   <= cs_n_d;
      sclk_q   <= sclk_d;
      sh_q     <= sh_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      ovr_q    <= ovr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign cs_n     = cs_n_q;
  assign sclk     = sclk_q;
  assign busy     = ~cs_n_q;
  assign m_tvalid = tvalid_q;
  assign m_tdata  = tdata_q;
  assign m_tlast  = tvalid_q && (cnt_q == CntW'(FRAME_LEN - 1));
  assign overrun  = ovr_q;

endmodule
